// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//   Downstream stage of the sequential shift-add multiplier. Each product the
//   multiplier announces on Done_Flag is captured with a 4-phase
//   ack/ret_ack handshake and added into an unsigned accumulator. After the
//   programmed number of products the total is offered on a valid/ready port
//   towards the result writer.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   start      in   1-cycle pulse, begins a new sum and samples len
//   len        in   number of products to accumulate
//   prod       in   product from the multiplier, stable while Done_Flag=1
//   Done_Flag  in   multiplier result ready
//   ret_ack    in   multiplier has seen ack and released Done_Flag
//   ack        out  product captured
//   busy       out  high in every state except IDLE
//   sum        out  accumulated result, valid while sum_valid=1
//   sum_valid  out  result available
//   sum_ready  in   consumer accepts sum
//   overflow   out  sticky carry out of the accumulator during this run
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int SIZE    = 32,
    parameter int COUNT_W = 8,
    parameter int ACC_W   = 2 * SIZE + COUNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [COUNT_W-1:0]  len,
    input  logic [2*SIZE-1:0]   prod,
    input  logic                Done_Flag,
    input  logic                ret_ack,
    output logic                ack,
    output logic                busy,
    output logic [ACC_W-1:0]    sum,
    output logic                sum_valid,
    input  logic                sum_ready,
    output logic                overflow
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DONE,
        ST_ACK,
        ST_WAIT_REL,
        ST_OUT
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [COUNT_W-1:0]   remaining_q, remaining_d;
    logic [ACC_W-1:0]     sum_q, sum_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 sum_valid_q, sum_valid_d;
    logic                 overflow_q, overflow_d;

    // Product zero-extended to one bit wider than the accumulator so the
    // carry out of the addition lands in the top bit.
    logic [ACC_W:0]       prod_ext;
    logic [ACC_W:0]       add_full;

    always_comb begin
        prod_ext = {{(ACC_W + 1 - 2 * SIZE){1'b0}}, prod};
        add_full = {1'b0, acc_q} + prod_ext;
    end

    // Next-state and next-output logic. Every output is a flop, so each one
    // is computed here for the state being entered.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        ack_d       = ack_q;
        sum_valid_d = sum_valid_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                // Done_Flag is deliberately not looked at here.
                if (start) begin
                    acc_d       = '0;
                    overflow_d  = 1'b0;
                    remaining_d = len;
                    sum_d       = '0;
                    if (len != '0) begin
                        state_d = ST_WAIT_DONE;
                    end else begin
                        sum_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end
                end
            end

            ST_WAIT_DONE: begin
                if (Done_Flag) begin
                    acc_d       = add_full[ACC_W-1:0];
                    overflow_d  = overflow_q | add_full[ACC_W];
                    remaining_d = remaining_q - COUNT_W'(1);
                    ack_d       = 1'b1;
                    state_d     = ST_ACK;
                end
            end

            ST_ACK: begin
                // Holding ack until Done_Flag has actually dropped guarantees
                // a long Done_Flag pulse is only ever added once.
                if (ret_ack && !Done_Flag) begin
                    ack_d   = 1'b0;
                    state_d = ST_WAIT_REL;
                end
            end

            ST_WAIT_REL: begin
                // One cycle with ack low before the next Done_Flag may be taken.
                if (remaining_q == '0) begin
                    sum_d       = acc_q;
                    sum_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_OUT: begin
                if (sum_ready) begin
                    sum_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset; reset wins even in
    // the middle of a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            sum_q       <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            sum_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            sum_valid_q <= sum_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//   Directed bench for product_accumulator. Two instances share the same
//   stimulus: the default 72-bit accumulator and a 64-bit accumulator so the
//   wrap-around and overflow flag can be exercised. Expected totals are
//   pushed into a scoreboard queue as products are driven and popped when
//   the design presents its result.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   len;
    logic [63:0]  prod;
    logic         Done_Flag;
    logic         ret_ack;
    logic         sum_ready;

    logic         ack, busy, sum_valid, overflow;
    logic [71:0]  sum;
    logic         ack64, busy64, sum_valid64, overflow64;
    logic [63:0]  sum64;

    typedef struct packed {
        logic [71:0] s72;
        logic        o72;
        logic [63:0] s64;
        logic        o64;
    } exp_t;

    exp_t         expQ[$];
    logic [79:0]  modelAcc;
    int           checks = 0;
    int           errors = 0;
    int           ackHighCount = 0;
    int           base;

    product_accumulator dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .prod(prod),
        .Done_Flag(Done_Flag), .ret_ack(ret_ack), .ack(ack), .busy(busy),
        .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .overflow(overflow)
    );

    product_accumulator #(.ACC_W(64)) dut64 (
        .clk(clk), .reset(reset), .start(start), .len(len), .prod(prod),
        .Done_Flag(Done_Flag), .ret_ack(ret_ack), .ack(ack64), .busy(busy64),
        .sum(sum64), .sum_valid(sum_valid64), .sum_ready(sum_ready),
        .overflow(overflow64)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Counts cycles with ack high, sampled mid-cycle.
    always @(negedge clk) begin
        if (ack === 1'b1) ackHighCount++;
    end

    // Last-resort guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [79:0] observed,
                               input logic [79:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic startRun(input logic [7:0] n);
        modelAcc = '0;
        start    = 1'b1;
        len      = n;
        tick();
        start    = 1'b0;
        len      = 8'($urandom);
    endtask

    // Drives one product through the full 4-phase handshake. Returns just
    // after the edge on which ack dropped; unless this is the last product,
    // one more cycle is spent so the design is back waiting for Done_Flag.
    task automatic applyStimulus(input logic [63:0] p, input bit last);
        int waited;
        prod      = p;
        Done_Flag = 1'b1;
        waited    = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            waited++;
            if (ack) break;
        end
        checkOutput("ack_rise_latency", 80'(waited), 80'd1);
        modelAcc  = modelAcc + {16'b0, p};
        Done_Flag = 1'b0;
        ret_ack   = 1'b1;
        prod      = {$urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!ack) break;
        end
        checkOutput("ack_release", 80'(ack), 80'd0);
        ret_ack = 1'b0;
        if (!last) tick();
    endtask

    task automatic pushExpected();
        exp_t e;
        e.s72 = modelAcc[71:0];
        e.o72 = |modelAcc[79:72];
        e.s64 = modelAcc[63:0];
        e.o64 = |modelAcc[79:64];
        expQ.push_back(e);
    endtask

    // Waits (bounded) for a result, compares it against the scoreboard and
    // completes the valid/ready handshake.
    task automatic collectOutput(input string tag);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            if (sum_valid) break;
            tick();
        end
        checkOutput({tag, "_valid"}, 80'(sum_valid), 80'd1);
        checkOutput({tag, "_valid64"}, 80'(sum_valid64), 80'd1);
        checkOutput({tag, "_queue_nonempty"}, 80'(expQ.size() != 0), 80'd1);
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput({tag, "_sum72"}, 80'(sum), 80'(e.s72));
            checkOutput({tag, "_ovf72"}, 80'(overflow), 80'(e.o72));
            checkOutput({tag, "_sum64"}, 80'(sum64), 80'(e.s64));
            checkOutput({tag, "_ovf64"}, 80'(overflow64), 80'(e.o64));
        end
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        checkOutput({tag, "_valid_cleared"}, 80'(sum_valid), 80'd0);
        checkOutput({tag, "_idle"}, 80'(busy), 80'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; prod = '0;
        Done_Flag = 1'b0; ret_ack = 1'b0; sum_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset_ack", 80'(ack), 80'd0);
        checkOutput("reset_busy", 80'(busy), 80'd0);
        checkOutput("reset_sum", 80'(sum), 80'd0);
        checkOutput("reset_valid", 80'(sum_valid), 80'd0);
        checkOutput("reset_ovf", 80'(overflow), 80'd0);
        reset = 1'b0;
        tick();

        $display("[TB] test 1: three products 6, 35, 100");
        startRun(8'd3);
        checkOutput("t1_busy", 80'(busy), 80'd1);
        applyStimulus(64'd6, 1'b0);
        applyStimulus(64'd35, 1'b0);
        applyStimulus(64'd100, 1'b1);
        pushExpected();
        checkOutput("t1_not_valid_yet", 80'(sum_valid), 80'd0);
        tick();
        checkOutput("t1_valid_latency", 80'(sum_valid), 80'd1);
        checkOutput("t1_sum_141", 80'(sum), 80'd141);
        collectOutput("t1");

        $display("[TB] test 2: Done_Flag in IDLE ignored, then len=0");
        base = ackHighCount;
        Done_Flag = 1'b1;
        prod = 64'd55;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("t2_idle_no_ack", 80'(ack), 80'd0);
        checkOutput("t2_idle_not_busy", 80'(busy), 80'd0);
        Done_Flag = 1'b0;
        startRun(8'd0);
        pushExpected();
        collectOutput("t2");
        checkOutput("t2_never_acked", 80'(ackHighCount - base), 80'd0);

        $display("[TB] test 3: long Done_Flag with start overlap and late ret_ack");
        modelAcc = '0;
        base = ackHighCount;
        start = 1'b1; len = 8'd1; Done_Flag = 1'b1; prod = 64'h1234;
        tick();
        start = 1'b0; len = 8'hAA;
        checkOutput("t3_no_capture_on_start", 80'(ack), 80'd0);
        tick();
        checkOutput("t3_ack_next_cycle", 80'(ack), 80'd1);
        for (int c = 3; c <= 10; c++) begin
            if (c == 8) ret_ack = 1'b1;
            tick();
            checkOutput("t3_ack_held", 80'(ack), 80'd1);
        end
        Done_Flag = 1'b0;
        prod = 64'hDEAD;
        tick();
        checkOutput("t3_ack_dropped", 80'(ack), 80'd0);
        ret_ack = 1'b0;
        checkOutput("t3_ack_cycles", 80'(ackHighCount - base), 80'd9);
        modelAcc = 80'h1234;
        pushExpected();
        collectOutput("t3");

        $display("[TB] test 4: all-ones products wrap the 64-bit accumulator");
        startRun(8'd2);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        pushExpected();
        collectOutput("t4");

        $display("[TB] test 5: consumer stalls, start pulses ignored");
        startRun(8'd1);
        applyStimulus(64'd9, 1'b1);
        pushExpected();
        tick();
        for (int c = 0; c < 20; c++) begin
            start = (c % 5 == 2);
            len   = 8'd3;
            tick();
            checkOutput("t5_valid_stable", 80'(sum_valid), 80'd1);
            checkOutput("t5_sum_stable", 80'(sum), 80'd9);
        end
        start = 1'b0;
        checkOutput("t5_busy_in_out", 80'(busy), 80'd1);
        collectOutput("t5");
        tick();
        checkOutput("t5_stays_idle", 80'(busy), 80'd0);

        $display("[TB] test 6: reset in the middle of a handshake");
        startRun(8'd4);
        applyStimulus(64'd5, 1'b0);
        Done_Flag = 1'b1;
        prod = 64'd11;
        tick();
        checkOutput("t6_in_ack", 80'(ack), 80'd1);
        reset = 1'b1;
        tick();
        checkOutput("t6_rst_ack", 80'(ack), 80'd0);
        checkOutput("t6_rst_busy", 80'(busy), 80'd0);
        checkOutput("t6_rst_sum", 80'(sum), 80'd0);
        checkOutput("t6_rst_valid", 80'(sum_valid), 80'd0);
        reset = 1'b0;
        Done_Flag = 1'b0;
        tick();
        startRun(8'd1);
        applyStimulus(64'd7, 1'b1);
        pushExpected();
        collectOutput("t6");
        checkOutput("scoreboard_drained", 80'(expQ.size()), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
